ppwm_mc_core: RTL

PPWM_MC_CORE -- requirements
Module: ppwm_mc_core

---
 rtl/ppwm_mc_core.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ppwm_mc_core.sv
// Programmable multi-channel PWM core: shared program memory, one tiny sequencer per channel.
// Define PPWM_SAT_EN to make ARITH saturate at 0 / 2^WIDTH-1 instead of wrapping.
module ppwm_mc_core #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int CHANNELS = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     prog_we_i,
   input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
   input  logic [WIDTH+3:0]         prog_data_i,
   output logic [WIDTH-1:0]         cntr_o,
   output logic [CHANNELS-1:0]      pwm_o,
   output logic [CHANNELS-1:0]      halted_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      CMD_CTRL     = 3'd0,
      CMD_SET      = 3'd1,
      CMD_ARITH    = 3'd2,
      CMD_SHIFT    = 3'd3,
      CMD_RSRV     = 3'd4,
      CMD_JUMP     = 3'd5,
      CMD_CMP_CNTR = 3'd6,
      CMD_BRANCH   = 3'd7
   } command_e;

   typedef enum logic {
      TRGT_PWM = 1'b0,
      TRGT_REG = 1'b1
   } target_e;

   logic [WIDTH+3:0] mem_q [DEPTH];
   logic [WIDTH-1:0] cntr_q;
   logic             cntr_max;
   logic             reload;

   assign cntr_max = (cntr_q == '1);
   assign reload   = enable_i && cntr_max;
   assign cntr_o   = cntr_q;

   // Program store and the free-running period counter; cleared memory reads back as NOP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cntr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (enable_i) cntr_q <= cntr_q + 1'b1;
         if (prog_we_i) mem_q[prog_addr_i] <= prog_data_i;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam logic [AW-1:0] START = AW'(c * (DEPTH / CHANNELS));

      logic [AW-1:0]    pc_q, pc_d, rel;
      logic [WIDTH-1:0] pwm_q, shd_q, shd_d, reg_q, reg_d;
      logic             flag_q, flag_d, halt_q, halt_d;
      logic [WIDTH+3:0] instr;
      command_e         op;
      target_e          tgt;
      logic [WIDTH-1:0] imm, opnd, cmp_val, res;
      logic             wr;

      assign instr   = mem_q[pc_q];
      assign op      = command_e'(instr[WIDTH+3:WIDTH+1]);
      assign tgt     = target_e'(instr[WIDTH]);
      assign imm     = instr[WIDTH-1:0];
      assign opnd    = (tgt == TRGT_PWM) ? shd_q : reg_q;
      assign cmp_val = (tgt == TRGT_PWM) ? imm : reg_q;
      assign rel     = AW'($signed(imm));

`ifdef PPWM_SAT_EN
      // Two guard bits: top bit flags underflow, next flags overflow past full scale.
      logic [WIDTH+1:0] sum;
      assign sum = {2'b00, opnd} + {{2{imm[WIDTH-1]}}, imm};
`else
      logic [WIDTH-1:0] sum;
      assign sum = opnd + imm;
`endif

      // One instruction per enabled cycle; WAIT and HALT hold the PC in place.
      always_comb begin
         pc_d   = pc_q;
         shd_d  = shd_q;
         reg_d  = reg_q;
         flag_d = flag_q;
         halt_d = halt_q;
         res    = opnd;
         wr     = 1'b0;
         if (enable_i && !halt_q) begin
            pc_d = pc_q + 1'b1;
            case (op)
               CMD_CTRL: begin
                  case (imm[1:0])
                     2'b01: if (!cntr_max) pc_d = pc_q;
                     2'b10: begin
                        halt_d = 1'b1;
                        pc_d   = pc_q;
                     end
                     2'b11: pc_d = START;
                     default: ;
                  endcase
               end
               CMD_SET: begin
                  res = imm;
                  wr  = 1'b1;
               end
               CMD_ARITH: begin
                  wr = 1'b1;
`ifdef PPWM_SAT_EN
                  if (sum[WIDTH+1])  res = '0;
                  else if (sum[WIDTH]) res = '1;
                  else                 res = sum[WIDTH-1:0];
`else
                  res = sum;
`endif
               end
               CMD_SHIFT: begin
                  wr  = 1'b1;
                  res = imm[WIDTH-1] ? (opnd >> imm[SW-1:0]) : (opnd << imm[SW-1:0]);
               end
               CMD_JUMP:     pc_d   = pc_q + rel;
               CMD_CMP_CNTR: flag_d = (cntr_q >= cmp_val);
               CMD_BRANCH:   if (flag_q) pc_d = pc_q + rel;
               default: ;
            endcase
            if (wr) begin
               if (tgt == TRGT_PWM) shd_d = res;
               else                 reg_d = res;
            end
         end
      end

      // Active duty only changes at the period boundary, so every period is glitch-free.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            pc_q   <= START;
            pwm_q  <= '0;
            shd_q  <= '0;
            reg_q  <= '0;
            flag_q <= 1'b0;
            halt_q <= 1'b0;
         end else begin
            pc_q   <= pc_d;
            shd_q  <= shd_d;
            reg_q  <= reg_d;
            flag_q <= flag_d;
            halt_q <= halt_d;
            if (reload) pwm_q <= shd_q;
         end
      end

      assign pwm_o[c]    = (cntr_q < pwm_q);
      assign halted_o[c] = halt_q;
   end

endmodule
